spi_reg_arbiter: RTL and testbench
==================================

Name: spi_reg_arbiter

Overview:
- Sits between the SPI byte-slave strobe/address/data interface and a bank of configuration registers used by the e-ink driver core.
- Synchronises the SCK-domain read and write strobes into the system clock domain.
- Services SPI accesses with bounded latency.
- Arbitrates the single-port register bank between SPI and a local core requester using a req/gnt handshake.

Parameters:
- NREGS, 8: number of 8-bit registers in the bank (1..256).
- AW, 8: address width for both the SPI and core ports.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- spi_addr  in  AW  SPI slave address (SCK domain; quasi-static while a strobe is high).
- spi_odata  in  8  SPI write data.
- spi_wrstb  in  1  SPI write strobe (SCK domain).
- spi_rdstb  in  1  SPI read strobe (SCK domain).
- spi_idata  out  8  read data returned to the SPI slave.
- core_req  in  1  core access request.
- core_we  in  1  core access type: 1 = write, 0 = read.
- core_addr  in  AW  core address.
- core_wdata  in  8  core write data.
- core_gnt  out  1  one-cycle grant pulse.
- core_rdata  out  8  core read data.
- core_rvalid  out  1  core read data valid.
- regs_flat  out  NREGS*8  all registers; reg i is at [8i+7:8i].
- core_wdrop  out  1  core write was dropped (present only with WLOCK_EN).

Interface (already decided):
- One clock: clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset state (rst_n low, asynchronous): all registers 0x00; synchronisers 0; FSM IDLE; spi_idata 0x00; core_gnt, core_rvalid and core_wdrop 0; core_rdata 0x00; pending flags cleared. Reset mid-access aborts the access with no bank write.
- Clock ratio: f_clk >= 12 x f_SCK is required. The SPI read latency (rdstb rise to spi_idata valid) is at most 4 clk, which fits inside half an SCK period.
- Strobe synchronisation:
  - spi_wrstb and spi_rdstb each pass through a 2-flop synchroniser plus rising-edge detect.
  - A detected edge sets a sticky pending flag (wr_pend or rd_pend).
  - spi_addr and spi_odata are sampled into holding registers in the same cycle the edge is detected.
  - A second edge arriving before the first is serviced overwrites the holding registers; this is unreachable within the clock ratio.
- FSM states: IDLE, SPI_WR, SPI_RD, CORE. Exactly one bank access per cycle.
- IDLE priority:
  1. rd_pend -> SPI_RD
  2. wr_pend -> SPI_WR
  3. core_req -> CORE
- Fairness: if core_req was high when an SPI state was entered, CORE is taken next, ahead of any further SPI pend. This bounds core wait to 3 cycles.
- SPI_WR:
  - Write hold_data to hold_addr if hold_addr < NREGS; otherwise discard.
  - Clear wr_pend.
  - Next state: CORE if the fairness flag is set, else IDLE.
- SPI_RD:
  - spi_idata <= bank[hold_addr], or 0x00 if hold_addr >= NREGS.
  - Clear rd_pend.
  - spi_idata holds its value until the next SPI_RD.
- CORE:
  - core_gnt = 1 for this cycle.
  - Write: bank[core_addr] <= core_wdata if core_addr < NREGS.
  - Read: core_rdata <= bank[core_addr] (0x00 if out of range), with core_rvalid = 1 on the following cycle.
  - Return to IDLE.
  - The core must hold req/we/addr/wdata stable until gnt and deassert or change req on the cycle after gnt; a req still high then is a new request.
- Simultaneous SPI write and core write to the same address: the SPI write occurs first and the core write follows, so the core value is the final value.
- Simultaneous rd and wr pending: read is serviced first (read-before-write ordering for auto-increment streams).
- regs_flat reflects bank contents combinationally from the register flops.

Optional Feature:
- Macro: SPI_REG_ARBITER_WLOCK_EN.
- With the macro defined:
  - Bit 7 of register NREGS-1 is a lock bit.
  - While it is 1, core writes to any address are dropped: core_gnt still pulses and core_wdrop pulses in the same cycle.
  - SPI writes are always accepted, so the host can clear the lock.
  - Core reads are unaffected.
- Without the macro: the lock bit is ordinary storage, the core_wdrop port is absent, and core writes always proceed.

Test Plan:
- SPI write: addr 0x03, data 0xA5, wrstb pulse -> regs_flat[31:24] = 0xA5 within 4 clk of the strobe rise; no core_gnt.
- SPI read: reg 2 = 0x5C, rdstb pulse with addr 0x02 -> spi_idata = 0x5C within 4 clk; out-of-range addr 0x40 -> 0x00.
- Core read/write:
  - core write 0x11 to addr 0x01 -> core_gnt one cycle, reg1 = 0x11.
  - core read addr 0x01 -> core_rvalid one cycle after gnt, core_rdata = 0x11.
- Collision: SPI write 0x22 and core write 0x33 to addr 0x04 in the same cycle -> SPI serviced first, core_gnt within 3 cycles, final reg4 = 0x33.
- Reset: assert rst_n low during SPI_WR -> all regs 0x00, outputs 0, no bank write; after release a fresh SPI write succeeds.
- WLOCK_EN: SPI writes 0x80 to addr 0x07; core writes 0x44 to addr 0x00 -> core_gnt and core_wdrop pulse, reg0 unchanged; SPI writes 0x00 to addr 0x07, then the core write succeeds.

Source files
------------

// File: rtl/spi_reg_arbiter_if.sv
// Bus bundle for spi_reg_arbiter: SPI byte-slave strobe/address/data signals
// plus the core req/gnt register access port.
// Optional macro SPI_REG_ARBITER_WLOCK_EN adds the core_wdrop signal.
interface spi_reg_arbiter_if #(
   parameter int AW = 8
);
   logic [AW-1:0] spi_addr;
   logic [7:0]    spi_odata;
   logic          spi_wrstb;
   logic          spi_rdstb;
   logic [7:0]    spi_idata;

   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [7:0]    core_wdata;
   logic          core_gnt;
   logic [7:0]    core_rdata;
   logic          core_rvalid;
`ifdef SPI_REG_ARBITER_WLOCK_EN
   logic          core_wdrop;

   modport master (
      output spi_addr, spi_odata, spi_wrstb, spi_rdstb,
      output core_req, core_we, core_addr, core_wdata,
      input  spi_idata, core_gnt, core_rdata, core_rvalid, core_wdrop
   );
   modport slave (
      input  spi_addr, spi_odata, spi_wrstb, spi_rdstb,
      input  core_req, core_we, core_addr, core_wdata,
      output spi_idata, core_gnt, core_rdata, core_rvalid, core_wdrop
   );
`else
   modport master (
      output spi_addr, spi_odata, spi_wrstb, spi_rdstb,
      output core_req, core_we, core_addr, core_wdata,
      input  spi_idata, core_gnt, core_rdata, core_rvalid
   );
   modport slave (
      input  spi_addr, spi_odata, spi_wrstb, spi_rdstb,
      input  core_req, core_we, core_addr, core_wdata,
      output spi_idata, core_gnt, core_rdata, core_rvalid
   );
`endif
endinterface

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: single-port 8-bit register bank shared between an SPI
// byte slave (SCK-domain strobes, synchronised here) and a local core port.
// Optional macro SPI_REG_ARBITER_WLOCK_EN: bit 7 of the last register locks
// out core writes (reported on core_wdrop); SPI writes are always accepted.
module spi_reg_arbiter #(
   parameter int NREGS = 8,
   parameter int AW    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   spi_reg_arbiter_if.slave    bus,
   output logic [NREGS*8-1:0]  regs_flat
);
   localparam int            IW        = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [AW:0]   NREGS_LIM = (AW+1)'(NREGS);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NREGS - 1);

   typedef enum logic [1:0] {IDLE, SPI_WR, SPI_RD, CORE} state_t;

   state_t        state;
   logic [7:0]    bank [NREGS];
   logic [2:0]    wr_sync;
   logic [2:0]    rd_sync;
   logic          wr_pend;
   logic          rd_pend;
   logic [AW-1:0] hold_addr;
   logic [7:0]    hold_data;
   logic          fair;
   logic          drop;
   logic [7:0]    spi_idata;
   logic          core_gnt;
   logic [7:0]    core_rdata;
   logic          core_rvalid;

   logic          wr_edge;
   logic          rd_edge;
   logic          wr_req;
   logic          rd_req;
   logic          hold_ok;
   logic          core_ok;
   logic [IW-1:0] hold_idx;
   logic [IW-1:0] core_idx;
   logic          lock_nxt;

   assign wr_edge  = wr_sync[1] & ~wr_sync[2];
   assign rd_edge  = rd_sync[1] & ~rd_sync[2];
   // An edge is serviced straight away from IDLE so SPI latency stays within 4 clk
   assign wr_req   = wr_edge | wr_pend;
   assign rd_req   = rd_edge | rd_pend;
   assign hold_ok  = ({1'b0, hold_addr} < NREGS_LIM);
   assign core_ok  = ({1'b0, bus.core_addr} < NREGS_LIM);
   assign hold_idx = hold_addr[IW-1:0];
   assign core_idx = bus.core_addr[IW-1:0];

`ifdef SPI_REG_ARBITER_WLOCK_EN
   // Lock value as it will be during the coming CORE cycle, including an SPI write landing now
   assign lock_nxt = (state == SPI_WR && hold_ok && hold_idx == LAST_IDX) ?
                     hold_data[7] : bank[NREGS-1][7];
   assign bus.core_wdrop = drop;
`else
   assign lock_nxt = 1'b0;
`endif

   assign bus.spi_idata   = spi_idata;
   assign bus.core_gnt    = core_gnt;
   assign bus.core_rdata  = core_rdata;
   assign bus.core_rvalid = core_rvalid;

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat[8*g +: 8] = bank[g];
   end

   // Two-flop synchronisers on the SCK-domain strobes plus one delay flop for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sync <= '0;
         rd_sync <= '0;
      end else begin
         wr_sync <= {wr_sync[1:0], bus.spi_wrstb};
         rd_sync <= {rd_sync[1:0], bus.spi_rdstb};
      end
   end

   // Capture SPI address/data on a strobe edge and keep sticky pend flags until serviced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_addr <= '0;
         hold_data <= 8'h00;
         wr_pend   <= 1'b0;
         rd_pend   <= 1'b0;
      end else begin
         if (wr_edge || rd_edge) begin
            hold_addr <= bus.spi_addr;
            hold_data <= bus.spi_odata;
         end
         if (wr_edge)
            wr_pend <= 1'b1;
         else if (state == SPI_WR)
            wr_pend <= 1'b0;
         if (rd_edge)
            rd_pend <= 1'b1;
         else if (state == SPI_RD)
            rd_pend <= 1'b0;
      end
   end

   // Arbitration FSM owning the single bank port and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fair        <= 1'b0;
         drop        <= 1'b0;
         spi_idata   <= 8'h00;
         core_gnt    <= 1'b0;
         core_rdata  <= 8'h00;
         core_rvalid <= 1'b0;
         for (int i = 0; i < NREGS; i++) bank[i] <= 8'h00;
      end else begin
         core_gnt    <= 1'b0;
         core_rvalid <= 1'b0;
         drop        <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rd_req) begin
                  state <= SPI_RD;
                  fair  <= bus.core_req;
               end else if (wr_req) begin
                  state <= SPI_WR;
                  fair  <= bus.core_req;
               end else if (bus.core_req) begin
                  state    <= CORE;
                  core_gnt <= 1'b1;
                  drop     <= bus.core_we & lock_nxt;
               end
            end
            SPI_WR, SPI_RD: begin
               if (state == SPI_WR) begin
                  if (hold_ok) bank[hold_idx] <= hold_data;
               end else begin
                  spi_idata <= hold_ok ? bank[hold_idx] : 8'h00;
               end
               fair <= 1'b0;
               // A core request waiting when the SPI access started goes next
               if (fair && bus.core_req) begin
                  state    <= CORE;
                  core_gnt <= 1'b1;
                  drop     <= bus.core_we & lock_nxt;
               end else begin
                  state <= IDLE;
               end
            end
            CORE: begin
               if (bus.core_we) begin
                  if (core_ok && !drop) bank[core_idx] <= bus.core_wdata;
               end else begin
                  core_rdata  <= core_ok ? bank[core_idx] : 8'h00;
                  core_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Testbench for spi_reg_arbiter: directed SPI/core transactions against a
// register-bank model, plus an idle-cycle compare process.
module tb_spi_reg_arbiter;
   localparam int NREGS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] regs_flat;

   int          vectors = 0;
   int          miscompares = 0;
   bit          chk_en = 1'b0;

   logic [7:0]  m_regs [NREGS];
   logic [7:0]  m_idata = 8'h00;
   logic [7:0]  m_rdata = 8'h00;

   spi_reg_arbiter_if #(.AW(8)) bus ();

   spi_reg_arbiter #(.NREGS(NREGS), .AW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .regs_flat (regs_flat)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] m_flat();
      logic [63:0] f;
      for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
      return f;
   endfunction

   function automatic logic [7:0] m_read(input int addr);
      return (addr < NREGS) ? m_regs[addr] : 8'h00;
   endfunction

   function automatic bit m_lock();
`ifdef SPI_REG_ARBITER_WLOCK_EN
      return m_regs[NREGS-1][7];
`else
      return 1'b0;
`endif
   endfunction

   // Between transactions every output must match the model exactly
   always @(negedge clk) begin
      if (chk_en) begin
         chk("idle regs_flat", regs_flat, m_flat());
         chk("idle spi_idata", bus.spi_idata, m_idata);
         chk("idle core_gnt", bus.core_gnt, 0);
         chk("idle core_rvalid", bus.core_rvalid, 0);
         chk("idle core_rdata", bus.core_rdata, m_rdata);
`ifdef SPI_REG_ARBITER_WLOCK_EN
         chk("idle core_wdrop", bus.core_wdrop, 0);
`endif
      end
   end

   task automatic spi_write(input int addr, input logic [7:0] data);
      bit anyg = 1'b0;
      chk_en = 1'b0;
      @(posedge clk); #1;
      bus.spi_addr = addr[7:0]; bus.spi_odata = data; bus.spi_wrstb = 1'b1;
      repeat (4) begin @(posedge clk); #1; anyg |= bus.core_gnt; end
      if (addr < NREGS) begin
         m_regs[addr] = data;
         chk($sformatf("spi_wr reg%0d", addr), regs_flat[8*addr +: 8], data);
      end else begin
         chk($sformatf("spi_wr oor %0h", addr), regs_flat, m_flat());
      end
      chk("spi_wr no core_gnt", anyg, 0);
      repeat (2) @(posedge clk); #1;
      bus.spi_wrstb = 1'b0;
      repeat (8) @(posedge clk); #1;
      chk_en = 1'b1;
   endtask

   task automatic spi_read(input int addr, input logic [7:0] exp);
      chk_en = 1'b0;
      @(posedge clk); #1;
      bus.spi_addr = addr[7:0]; bus.spi_rdstb = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk($sformatf("spi_rd %0h data", addr), bus.spi_idata, exp);
      chk($sformatf("spi_rd %0h model", addr), m_read(addr), exp);
      m_idata = exp;
      repeat (2) @(posedge clk); #1;
      bus.spi_rdstb = 1'b0;
      repeat (8) @(posedge clk); #1;
      chk_en = 1'b1;
   endtask

   // exp is the read data for reads, or the resulting register value for writes
   task automatic core_access(input logic we, input int addr, input logic [7:0] wdata,
                              input logic [7:0] exp, input string tag);
      bit got = 1'b0;
      bit exp_drop;
      chk_en = 1'b0;
      @(posedge clk); #1;
      bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr[7:0]; bus.core_wdata = wdata;
      for (int n = 0; n < 3 && !got; n++) begin
         @(posedge clk); #1;
         if (bus.core_gnt) got = 1'b1;
      end
      chk({tag, " gnt within 3"}, got, 1);
      if (got) begin
         exp_drop = we && m_lock();
`ifdef SPI_REG_ARBITER_WLOCK_EN
         chk({tag, " wdrop"}, bus.core_wdrop, exp_drop);
`endif
         @(posedge clk); #1;
         chk({tag, " gnt one cycle"}, bus.core_gnt, 0);
         if (!we) begin
            chk({tag, " rvalid"}, bus.core_rvalid, 1);
            chk({tag, " rdata"}, bus.core_rdata, exp);
            m_rdata = m_read(addr);
         end else if (!exp_drop && addr < NREGS) begin
            m_regs[addr] = wdata;
         end
         chk({tag, " model"}, m_read(addr), exp);
      end
      bus.core_req = 1'b0; bus.core_we = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk_en = 1'b1;
   endtask

   task automatic collision();
      bit got = 1'b0;
      logic [7:0] r4 = 8'h00;
      chk_en = 1'b0;
      @(posedge clk); #1;
      bus.spi_addr = 8'h04; bus.spi_odata = 8'h22; bus.spi_wrstb = 1'b1;
      repeat (2) @(posedge clk); #1;
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h04; bus.core_wdata = 8'h33;
      for (int n = 0; n < 3 && !got; n++) begin
         @(posedge clk); #1;
         if (bus.core_gnt) begin got = 1'b1; r4 = regs_flat[39:32]; end
      end
      chk("coll gnt within 3", got, 1);
      chk("coll spi first", r4, 8'h22);
      @(posedge clk); #1;
      bus.core_req = 1'b0; bus.core_we = 1'b0;
      chk("coll gnt one cycle", bus.core_gnt, 0);
      chk("coll final reg4", regs_flat[39:32], 8'h33);
      m_regs[4] = 8'h33;
      repeat (2) @(posedge clk); #1;
      bus.spi_wrstb = 1'b0;
      repeat (8) @(posedge clk); #1;
      chk_en = 1'b1;
   endtask

   task automatic reset_mid_write();
      chk_en = 1'b0;
      @(posedge clk); #1;
      bus.spi_addr = 8'h05; bus.spi_odata = 8'h77; bus.spi_wrstb = 1'b1;
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b0; bus.spi_wrstb = 1'b0;
      #1;
      chk("rst regs_flat", regs_flat, 64'h0);
      chk("rst spi_idata", bus.spi_idata, 0);
      chk("rst core_gnt", bus.core_gnt, 0);
      chk("rst core_rvalid", bus.core_rvalid, 0);
      chk("rst core_rdata", bus.core_rdata, 0);
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      m_idata = 8'h00; m_rdata = 8'h00;
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("rst no late write", regs_flat[47:40], 8'h00);
      chk_en = 1'b1;
      spi_write(5, 8'h77);
      chk("rst fresh write reg5", regs_flat[47:40], 8'h77);
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      bus.spi_addr = '0; bus.spi_odata = '0; bus.spi_wrstb = 1'b0; bus.spi_rdstb = 1'b0;
      bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
      repeat (3) @(posedge clk); #1;
      chk("reset regs_flat", regs_flat, 64'h0);
      chk("reset spi_idata", bus.spi_idata, 0);
      chk("reset core_gnt", bus.core_gnt, 0);
      chk("reset core_rvalid", bus.core_rvalid, 0);
      chk("reset core_rdata", bus.core_rdata, 0);
`ifdef SPI_REG_ARBITER_WLOCK_EN
      chk("reset core_wdrop", bus.core_wdrop, 0);
`endif
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk_en = 1'b1;

      spi_write(3, 8'hA5);
      chk("plan reg3", regs_flat[31:24], 8'hA5);
      spi_write(2, 8'h5C);
      spi_read(2, 8'h5C);
      spi_read(8'h40, 8'h00);
      spi_read(3, 8'hA5);

      core_access(1'b1, 1, 8'h11, 8'h11, "core wr reg1");
      chk("plan reg1", regs_flat[15:8], 8'h11);
      core_access(1'b0, 1, 8'h00, 8'h11, "core rd reg1");

      spi_write(8, 8'h99);
      spi_write(7, 8'h7E);
      spi_read(7, 8'h7E);
      core_access(1'b1, 9, 8'h55, 8'h00, "core wr oor");
      core_access(1'b0, 8'h40, 8'h00, 8'h00, "core rd oor");
      core_access(1'b0, 3, 8'h00, 8'hA5, "core rd reg3");

      collision();
      reset_mid_write();

`ifdef SPI_REG_ARBITER_WLOCK_EN
      spi_write(7, 8'h80);
      chk("lock model set", m_lock(), 1);
      core_access(1'b1, 0, 8'h44, 8'h00, "locked core wr");
      chk("locked reg0", regs_flat[7:0], 8'h00);
      core_access(1'b0, 7, 8'h00, 8'h80, "locked core rd");
      spi_write(7, 8'h00);
      core_access(1'b1, 0, 8'h44, 8'h44, "unlocked core wr");
      chk("unlocked reg0", regs_flat[7:0], 8'h44);
`endif

      repeat (4) @(posedge clk); #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
